// File: rtl/fp_pkg.sv
// Shared constants and FSM encoding for the sequential single-precision subtractor.
package fp_pkg;

  localparam int          EXP_BIAS  = 127;
  localparam int          EXP_MAX   = 255;
  localparam logic [31:0] QNAN      = 32'h7FC00000;
  localparam int          ALIGN_CAP = 25;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ALIGN,
    ADDSUB,
    NORM,
    PACK
  } state_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational split of a single-precision word into fields; denormals flush to zero.
module fp_unpack (
  input  logic [31:0] word,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [23:0] sig,
  output logic        is_zero,
  output logic        is_special
);

  assign sign       = word[31];
  assign exp        = word[30:23];
  assign is_zero    = (word[30:23] == 8'h00);
  assign is_special = (word[30:23] == 8'hFF);
  assign sig        = is_zero ? '0 : {1'b1, word[22:0]};

endmodule

// File: rtl/fp_sub_seq.sv
// Multi-cycle single-precision subtractor (out = a - b), one-bit-per-cycle align/normalise.
module fp_sub_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] out
);

  state_t state, next;

  logic [31:0] a_r, b_r;
  logic        sa, sb, za, zb, na, nb;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;

  logic               xs, ys, nan_f, zero_f;
  logic [23:0]        mx, my;
  logic signed [9:0]  e;
  logic [4:0]         d;

  logic              swap;
  logic [7:0]        dx;
  logic [4:0]        d_cap;
  logic [24:0]       res;
  logic [23:0]       res_n;
  logic signed [9:0] e_n, e_dec;
  logic [23:0]       mx_shl;

  fp_unpack u_a (.word(a_r), .sign(sa), .exp(ea), .sig(ma), .is_zero(za), .is_special(na));
  fp_unpack u_b (.word(b_r), .sign(sb), .exp(eb), .sig(mb), .is_zero(zb), .is_special(nb));

  assign busy = (state != IDLE);

  always_comb begin
    swap   = (eb > ea) || ((eb == ea) && (mb > ma));
    dx     = swap ? (eb - ea) : (ea - eb);
    d_cap  = (dx > 8'(ALIGN_CAP)) ? 5'(ALIGN_CAP) : dx[4:0];
    res    = (xs == ys) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
    res_n  = res[24] ? res[24:1] : res[23:0];
    e_n    = res[24] ? (e + 10'sd1) : e;
    e_dec  = e - 10'sd1;
    mx_shl = {mx[22:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:   if (start) next = UNPACK;
      UNPACK: begin
        if (na || nb)        next = PACK;
        else if (d_cap != 0) next = ALIGN;
        else                 next = ADDSUB;
      end
      ALIGN:  if (d == 5'd1) next = ADDSUB;
      ADDSUB: begin
        if (res == '0 || res_n[23]) next = PACK;
        else                        next = NORM;
      end
      // Exit decision uses the post-shift values so each NORM cycle is exactly one shift.
      NORM:   if (e_dec <= 10'sd0 || mx_shl[23]) next = PACK;
      PACK:   next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0; b_r <= '0;
      xs <= 1'b0; ys <= 1'b0; mx <= '0; my <= '0;
      e <= '0; d <= '0; nan_f <= 1'b0; zero_f <= 1'b0;
      out <= '0; done <= 1'b0;
    end else begin
      done <= (state == PACK);
      case (state)
        IDLE: if (start) begin
          a_r    <= a;
          b_r    <= {~b[31], b[30:0]};
          nan_f  <= 1'b0;
          zero_f <= 1'b0;
        end
        UNPACK: begin
          xs    <= swap ? sb : sa;
          ys    <= swap ? sa : sb;
          mx    <= swap ? mb : ma;
          my    <= ((dx > 8'(ALIGN_CAP)) || (swap ? za : zb)) ? '0 : (swap ? ma : mb);
          e     <= $signed({2'b00, (swap ? eb : ea)});
          d     <= d_cap;
          nan_f <= na | nb;
        end
        ALIGN: begin
          my <= my >> 1;
          d  <= d - 5'd1;
        end
        ADDSUB: begin
          if (res == '0) zero_f <= 1'b1;
          mx <= res_n;
          e  <= e_n;
        end
        NORM: begin
          mx <= mx_shl;
          e  <= e_dec;
          if (e_dec <= 10'sd0) zero_f <= 1'b1;
        end
        PACK: begin
          if (nan_f)                    out <= QNAN;
          else if (zero_f)              out <= '0;
          else if (int'(e) >= EXP_MAX)  out <= {xs, 8'hFF, 23'h0};
          else                          out <= {xs, e[7:0], mx[22:0]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sub_seq.sv
// Directed bench for fp_sub_seq: results, latencies, reset abort and start handshake.
module tb_fp_sub_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] out;

  int n_checks = 0;
  int n_pass   = 0;

  fp_sub_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .out(out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  // Issues start in the current cycle (cycle 0) and returns #1 after the edge that raises done.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_out, input int exp_cyc);
    int cyc;
    start = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    cyc = 1;
    check({tag, "_busy_c1"}, 32'(busy), 32'd1);
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_out"}, out, exp_out);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_out", out, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("sub_20_15", 32'h41A00000, 32'h41700000, 32'h40A00000, 7);
    @(posedge clk); #1;
    check("done_pulse_once", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("out_held", out, 32'h40A00000);

    run_op("sub_15_20", 32'h41700000, 32'h41A00000, 32'hC0A00000, 7);
    @(posedge clk); #1;
    run_op("sub_15_m20", 32'h41700000, 32'hC1A00000, 32'h420C0000, 5);
    @(posedge clk); #1;
    run_op("sub_15_15", 32'h41700000, 32'h41700000, 32'h00000000, 4);
    @(posedge clk); #1;
    run_op("align_cap", 32'h4E800000, 32'h3F800000, 32'h4E800000, 29);
    @(posedge clk); #1;
    run_op("nan_in", 32'h7F800000, 32'h3F800000, 32'h7FC00000, 3);
    @(posedge clk); #1;

    // Back-to-back: second start asserted in the done cycle of the first.
    run_op("b2b_first", 32'h41A00000, 32'h41700000, 32'h40A00000, 7);
    run_op("b2b_second", 32'h41700000, 32'hC1A00000, 32'h420C0000, 5);
    @(posedge clk); #1;

    // A start pulse while busy must neither alter the running op nor queue another.
    start = 1'b1; a = 32'h41A00000; b = 32'h41700000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 32'h41700000; b = 32'h41700000;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        pulses++;
        check("ignored_start_out", out, 32'h40A00000);
      end
      @(posedge clk); #1;
    end
    check("ignored_start_pulses", 32'(pulses), 32'd1);

    // Reset raised in cycle 3 aborts the operation.
    start = 1'b1; a = 32'h41A00000; b = 32'h41700000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out", out, 32'h0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    check("abort_out_after", out, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
